// File: rtl/seg_pkg.sv
// Shared constants and types for the four-digit scanned seven-segment driver.
// Glyphs are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // One captured display image: four nibbles plus their decimal points.
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
    } seg_frame_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
// Purely combinational; no clock or reset.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] iHex,
    output logic [6:0] oSeg
);

    // Map each of the 16 codes to its standard hex glyph.
    always_comb begin
        oSeg = SEG_BLANK;
        unique case (iHex)
            4'h0: oSeg = SEG_0;
            4'h1: oSeg = SEG_1;
            4'h2: oSeg = SEG_2;
            4'h3: oSeg = SEG_3;
            4'h4: oSeg = SEG_4;
            4'h5: oSeg = SEG_5;
            4'h6: oSeg = SEG_6;
            4'h7: oSeg = SEG_7;
            4'h8: oSeg = SEG_8;
            4'h9: oSeg = SEG_9;
            4'hA: oSeg = SEG_A;
            4'hB: oSeg = SEG_B;
            4'hC: oSeg = SEG_C;
            4'hD: oSeg = SEG_D;
            4'hE: oSeg = SEG_E;
            4'hF: oSeg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with tear-free frame updates.
// Optional leading-zero blanking when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 2
)
(
    input  logic        CLK,
    input  logic        rst,
    input  logic [15:0] iValue,
    input  logic        iLoad,
    input  logic [3:0]  iDpMask,
    output logic [3:0]  oAn,
    output logic [6:0]  oSeg,
    output logic        oDp,
    output logic        oFrame
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] PRESC_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [CW:0]   DEAD_LIM   = (CW + 1)'(DEAD_CYCLES);

    logic [CW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    seg_frame_t    shadow_q, shadow_d;
    seg_frame_t    disp_q, disp_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;

    logic            slot_tick;
    logic            frame_tick;
    logic            dead;
    logic [3:0]      nib;
    logic [6:0]      glyph;
    logic [NUM_DIGITS-1:0] lz_blank;
    seg_frame_t      in_frame;

    assign in_frame   = '{value: iValue, dp: iDpMask};
    assign slot_tick  = (presc_q == PRESC_LAST);
    assign frame_tick = slot_tick && (idx_q == IDX_LAST);
    assign dead       = ({1'b0, presc_q} < DEAD_LIM);
    assign nib        = disp_q.value[{idx_q, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .iHex (nib),
        .oSeg (glyph)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    assign lz_blank = {
        disp_q.value[15:12] == 4'h0,
        disp_q.value[15:8]  == 8'h0,
        disp_q.value[15:4]  == 12'h0,
        1'b0
    };
`else
    assign lz_blank = '0;
`endif

    // Scan counters plus shadow/display capture; display only changes at frame wrap.
    always_comb begin
        presc_d  = presc_q + 1'b1;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        if (slot_tick) begin
            presc_d = '0;
            idx_d   = idx_q + 1'b1;
        end
        if (iLoad) begin
            shadow_d = in_frame;
        end
        if (frame_tick) begin
            disp_d = iLoad ? in_frame : shadow_q;
        end
    end

    // Output image for the current scan position, registered one cycle later.
    always_comb begin
        an_d    = 4'hF;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        frame_d = (presc_q == '0) && (idx_q == '0);
        if (!dead) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lz_blank[idx_q] ? SEG_BLANK : glyph;
            dp_d  = ~disp_q.dp[idx_q];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            an_q     <= 4'hF;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            frame_q  <= frame_d;
        end
    end

    assign oAn    = an_q;
    assign oSeg   = seg_q;
    assign oDp    = dp_q;
    assign oFrame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=4, DEAD_CYCLES=1).
// Directed vector table, hand sequences and randomized traffic vs a frame model.
module tb_seg_scan_driver;

    localparam int SD   = 4;
    localparam int DC   = 1;
    localparam int FLEN = 4 * SD;

`ifdef SEG_SCAN_LZ_BLANK_EN
    localparam logic [6:0] ZH = 7'h7F;
`else
    localparam logic [6:0] ZH = 7'h40;
`endif

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] iValue = '0;
    logic        iLoad = 1'b0;
    logic [3:0]  iDpMask = '0;
    logic [3:0]  oAn;
    logic [6:0]  oSeg;
    logic        oDp;
    logic        oFrame;

    seg_scan_driver #(
        .SCAN_DIV    (SD),
        .DEAD_CYCLES (DC)
    ) dut (
        .CLK     (CLK),
        .rst     (rst),
        .iValue  (iValue),
        .iLoad   (iLoad),
        .iDpMask (iDpMask),
        .oAn     (oAn),
        .oSeg    (oSeg),
        .oDp     (oDp),
        .oFrame  (oFrame)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [6:0] GLY [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: position within a 16-cycle frame and the frame images.
    int          m_pos = 0;
    logic [15:0] m_disp = '0, m_shadow = '0;
    logic [3:0]  m_ddp = '0, m_sdp = '0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fr;

    function automatic void model(input logic r, input logic l,
                                  input logic [15:0] v, input logic [3:0] d);
        int slot;
        int ph;
        logic [15:0] hi;
        if (r) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
            m_pos = 0; m_disp = '0; m_shadow = '0; m_ddp = '0; m_sdp = '0;
            return;
        end
        slot = m_pos / SD;
        ph   = m_pos % SD;
        e_fr = (m_pos == 0);
        if (ph < DC) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an  = 4'hF & ~(4'(1) << slot);
            hi    = m_disp >> (4 * slot);
            e_seg = GLY[hi[3:0]];
`ifdef SEG_SCAN_LZ_BLANK_EN
            if (slot > 0 && hi == 16'h0) e_seg = 7'h7F;
`endif
            e_dp = ~m_ddp[slot];
        end
        if (m_pos == FLEN - 1) begin
            m_disp = l ? v : m_shadow;
            m_ddp  = l ? d : m_sdp;
        end
        if (l) begin
            m_shadow = v;
            m_sdp    = d;
        end
        m_pos = (m_pos + 1) % FLEN;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic l,
                         input logic [15:0] v, input logic [3:0] d);
        rst = r; iLoad = l; iValue = v; iDpMask = d;
        @(posedge CLK);
        model(r, l, v, d);
        #1;
        chk("model_an", 32'(oAn), 32'(e_an));
        chk("model_seg", 32'(oSeg), 32'(e_seg));
        chk("model_dp", 32'(oDp), 32'(e_dp));
        chk("model_frame", 32'(oFrame), 32'(e_fr));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic wait_pos(input int t);
        int n = 0;
        while (m_pos != t && n < 2 * FLEN) begin
            idle();
            n++;
        end
        chk("wait_pos_bound", 32'(m_pos), 32'(t));
    endtask

    typedef struct {
        logic        r;
        logic        l;
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic l, input logic [15:0] v,
                                input logic [3:0] d, input logic [3:0] an,
                                input logic [6:0] seg, input logic dp, input logic fr,
                                input int n);
        vec_t x;
        x = '{r: r, l: l, v: v, d: d, an: an, seg: seg, dp: dp, fr: fr};
        for (int i = 0; i < n; i++) tbl.push_back(x);
    endfunction

    int nf;

    initial begin
        // Reset, load 1234 with DP on digit 1, then one frame of zeros and one of 1234.
        add(1, 0, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 3);
        add(0, 1, 16'h1234, 4'b0010, 4'hF, 7'h7F, 1, 1, 1);
        add(0, 0, 16'h0, 4'h0, 4'hE, 7'h40, 1, 0, 3);
        add(0, 0, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 1);
        add(0, 0, 16'h0, 4'h0, 4'hD, ZH, 1, 0, 3);
        add(0, 0, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 1);
        add(0, 0, 16'h0, 4'h0, 4'hB, ZH, 1, 0, 3);
        add(0, 0, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 1);
        add(0, 0, 16'h0, 4'h0, 4'h7, ZH, 1, 0, 3);
        add(0, 0, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 1, 1);
        add(0, 0, 16'h0, 4'h0, 4'hE, 7'h19, 1, 0, 3);
        add(0, 0, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 1);
        add(0, 0, 16'h0, 4'h0, 4'hD, 7'h30, 0, 0, 3);
        add(0, 0, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 1);
        add(0, 0, 16'h0, 4'h0, 4'hB, 7'h24, 1, 0, 3);
        add(0, 0, 16'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 1);
        add(0, 0, 16'h0, 4'h0, 4'h7, 7'h79, 1, 0, 3);

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].l, tbl[i].v, tbl[i].d);
            chk("tbl_an", 32'(oAn), 32'(tbl[i].an));
            chk("tbl_seg", 32'(oSeg), 32'(tbl[i].seg));
            chk("tbl_dp", 32'(oDp), 32'(tbl[i].dp));
            chk("tbl_frame", 32'(oFrame), 32'(tbl[i].fr));
        end

        // One frame pulse per 16 cycles.
        nf = 0;
        for (int i = 0; i < 4 * FLEN; i++) begin
            idle();
            if (oFrame) nf++;
        end
        chk("frame_count", 32'(nf), 32'd4);

        // Tear-free: AAAA shown, 5555 loaded while digit 1 active.
        wait_pos(0);
        cycle(1'b0, 1'b1, 16'hAAAA, 4'h0);
        wait_pos(0);
        wait_pos(5);
        cycle(1'b0, 1'b1, 16'h5555, 4'h0);
        wait_pos(10);
        idle();
        chk("tearfree_old_an", 32'(oAn), 32'h0B);
        chk("tearfree_old_seg", 32'(oSeg), 32'h08);
        wait_pos(0);
        wait_pos(2);
        idle();
        chk("tearfree_new_seg", 32'(oSeg), 32'h12);

        // Coincident load on the frame-boundary tick.
        wait_pos(FLEN - 1);
        cycle(1'b0, 1'b1, 16'h00FF, 4'h0);
        idle();
        idle();
        chk("coinc_d0_an", 32'(oAn), 32'h0E);
        chk("coinc_d0_seg", 32'(oSeg), 32'h0E);
        wait_pos(14);
        idle();
        chk("coinc_d3_seg", 32'(oSeg), 32'(ZH));

        // Reset mid-frame while digit 2 active and a load is pending.
        wait_pos(9);
        cycle(1'b0, 1'b1, 16'h9999, 4'hF);
        idle();
        cycle(1'b1, 1'b0, 16'h0, 4'h0);
        chk("midrst_an", 32'(oAn), 32'hF);
        chk("midrst_seg", 32'(oSeg), 32'h7F);
        cycle(1'b1, 1'b0, 16'h0, 4'h0);
        idle();
        chk("midrst_frame", 32'(oFrame), 32'h1);
        idle();
        chk("midrst_d0_an", 32'(oAn), 32'hE);
        chk("midrst_d0_seg", 32'(oSeg), 32'h40);
        chk("midrst_d0_dp", 32'(oDp), 32'h1);
        wait_pos(0);
        wait_pos(2);
        idle();
        chk("midrst_discard_seg", 32'(oSeg), 32'h40);

        // Randomized traffic against the frame model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255))
                                              : 16'($urandom),
                  4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL have parameter DEAD_CYCLES, default 2, giving the anode-off cycles at the start of each slot; legal range 0..SCAN_DIV-1.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port iValue, input, 16 bits: four hex nibbles; digit k = iValue[4k+3:4k], with digit 0 rightmost.
REQ-006 SHALL have port iLoad, input, 1 bit: single-cycle strobe that captures iValue.
REQ-007 SHALL have port iDpMask, input, 4 bits: decimal point enable per digit; sampled together with iValue.
REQ-008 SHALL have port oAn, output, 4 bits: one-hot-low digit enables.
REQ-009 SHALL have port oSeg, output, 7 bits: active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-010 SHALL have port oDp, output, 1 bit: active-low decimal point.
REQ-011 SHALL have port oFrame, output, 1 bit: one-cycle pulse at the start of each frame (digit 0 slot).

Function
REQ-012 SHALL run a prescaler counting 0..SCAN_DIV-1 that wraps to 0; the wrap cycle is the slot tick.
REQ-013 SHALL advance the digit index 0->1->2->3->0 on each slot tick; the 3->0 advance is the frame boundary.
REQ-014 SHALL register all outputs, each reflecting prescaler and index state of the previous cycle (1-cycle latency).
REQ-015 SHALL drive oAn=4'b1111 while prescaler < DEAD_CYCLES; otherwise oAn[index]=0 and all other bits 1.
REQ-016 SHALL drive oSeg and oDp from the active digit's nibble and DP bit; codes 0-F use standard hex glyphs, e.g. 0=7'b1000000, 8=7'b0000000, F=7'b0001110.
REQ-017 SHALL drive oSeg=7'h7F and oDp=1 during dead cycles.
REQ-018 SHALL write iValue and iDpMask into a shadow register on iLoad.
REQ-019 SHALL copy the shadow register into the display register only at the frame boundary, so no frame mixes old and new values.
REQ-020 SHALL, when iLoad coincides with the frame-boundary tick, write iValue directly to both shadow and display registers (new value wins).
REQ-021 SHALL keep only the last value when multiple iLoad pulses occur within one frame.
REQ-022 SHALL pulse oFrame for exactly one cycle, aligned with the first output cycle of digit 0's slot.

Reset
REQ-023 SHALL, while rst=1, hold prescaler=0, index=0, shadow and display registers=0, oAn=4'b1111, oSeg=7'h7F, oDp=1 and oFrame=0.
REQ-024 SHALL abort the current slot immediately when rst is asserted mid-frame, with no partial load surviving.
REQ-025 SHALL start digit 0 at prescaler 0 in the first cycle after rst deasserts, and issue oFrame one cycle later.

Configuration
REQ-026 SHALL, when SEG_SCAN_LZ_BLANK_EN is defined, suppress leading zeros.
- digit 3 is blanked if it is 0.
- digit 2 is blanked if digits 3 and 2 are 0.
- digit 1 is blanked if digits 3 through 1 are 0.
- digit 0 is never blanked.
- a blanked digit drives oSeg=7'h7F, while oAn still enables it and oDp still follows the mask.
REQ-027 SHALL, when SEG_SCAN_LZ_BLANK_EN is undefined, show all four digits, zeros included.

Structure
REQ-028 SHALL place NUM_DIGITS=4, the seven-segment glyph constants (active-low) and the blank code 7'h7F in a shared package seg_pkg.
REQ-029 SHALL implement hex-to-glyph decoding in a combinational sub-module hex7seg (4-bit in, 7-bit out), instantiated once.

Verification (SCAN_DIV=4, DEAD_CYCLES=1)
REQ-030 SHALL cover reset: hold rst 3 cycles then release -> oAn=1111, oSeg=7F during rst; digit 0 enabled (oAn=1110) from the 2nd cycle after release; oFrame pulses once per 16 cycles.
REQ-031 SHALL cover scan order: iLoad with iValue=16'h1234 -> display updates at the next frame; slots show 4 (7'b0011001), 3 (7'b0110000), 2 (7'b0100100), 1 (7'b1111001) on oAn 1110, 1101, 1011, 0111, each preceded by 1 dead cycle with oAn=1111.
REQ-032 SHALL cover tear-free update: load 16'hAAAA, then load 16'h5555 mid-frame while digit 1 is active -> the rest of that frame still shows A; the next frame shows 5 on all digits.
REQ-033 SHALL cover coincident load: iLoad with 16'h00FF on the frame-boundary tick -> that very frame shows F, F, 0, 0.
REQ-034 SHALL cover leading-zero blanking: with SEG_SCAN_LZ_BLANK_EN, iValue=16'h0007 -> digits 3..1 show 7F, digit 0 shows 7 (7'b1111000); without the macro -> 0, 0, 0, 7.
REQ-035 SHALL cover reset mid-frame: assert rst while digit 2 is active with a pending shadow load -> after release digit 0 restarts and shows 0, and the pending value is discarded.
